heu_rslt_rdr: RTL and testbench

Downstream reader for a heuristic stage's serial output buffer. It waits for the upstream stage to report a full result (prev_out_ready), then pulls NUM_WORDS words out of the upstream shift register one per cycle and stores them locally. It then releases the upstream stage with a one-cycle in_ready and streams the stored words to a memory write port over a valid/ready handshake with sequential addresses. It sits between the heu stage output and the result-memory writer.

---
 rtl/heu_rslt_rdr.sv | 109 ++++++++++
 tb/tb_heu_rslt_rdr.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/heu_rslt_rdr.sv
// Reader for the heuristic stage's serial result buffer: pulls a full block of
// words out of the upstream shift register, releases upstream, then writes the block out.
module heu_rslt_rdr #(
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 80,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_out_ready,
    input  logic [DATA_W-1:0] prev_data,
    output logic              prev_shift,
    output logic              in_ready,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  wr_addr,
    output logic              wr_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULL    = 2'd1,
        RELEASE = 2'd2,
        PUSH    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] word_buf [NUM_WORDS];

    // Control outputs are registered alongside the state so nothing reaches them from inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            prev_shift <= 1'b0;
            in_ready   <= 1'b0;
            wr_valid   <= 1'b0;
            wr_last    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (prev_out_ready) begin
                        state      <= PULL;
                        cnt        <= '0;
                        prev_shift <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                PULL: begin
                    if (cnt == LAST_IDX) begin
                        state      <= RELEASE;
                        cnt        <= '0;
                        prev_shift <= 1'b0;
                        in_ready   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    state    <= PUSH;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    wr_valid <= 1'b1;
                    wr_last  <= (LAST_IDX == '0);
                end
                PUSH: begin
                    if (wr_valid && wr_ready) begin
                        if (wr_last) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            wr_valid <= 1'b0;
                            wr_last  <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            wr_last <= ((cnt + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    prev_shift <= 1'b0;
                    in_ready   <= 1'b0;
                    wr_valid   <= 1'b0;
                    wr_last    <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == PULL) begin
            word_buf[cnt] <= prev_data;
        end
    end

    assign wr_addr = wr_valid ? cnt : '0;
    assign wr_data = wr_valid ? word_buf[cnt] : '0;

endmodule

// File: tb/tb_heu_rslt_rdr.sv
// Directed bench for heu_rslt_rdr: an upstream shift-register model feeds blocks,
// and each scenario task checks shift/release/write behaviour against hand-computed values.
module tb_heu_rslt_rdr;

    localparam int DATA_W    = 8;
    localparam int NUM_WORDS = 80;
    localparam int CNT_W     = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              prev_out_ready;
    logic [DATA_W-1:0] prev_data;
    logic              prev_shift;
    logic              in_ready;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  wr_addr;
    logic              wr_last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    heu_rslt_rdr #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .prev_out_ready (prev_out_ready),
        .prev_data      (prev_data),
        .prev_shift     (prev_shift),
        .in_ready       (in_ready),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .wr_addr        (wr_addr),
        .wr_last        (wr_last),
        .busy           (busy)
    );

    // Upstream shift register: the head word advances after every cycle prev_shift is high.
    int         model_idx = 0;
    logic [7:0] base0 = 8'h00;
    logic [7:0] base1 = 8'h00;

    always @(negedge clk) begin
        if (prev_shift === 1'b1) begin
            prev_data = (model_idx < NUM_WORDS) ? base0 + 8'(model_idx)
                                                : base1 + 8'(model_idx - NUM_WORDS);
            model_idx++;
        end
    end

    int         shift_cnt, first_shift, last_shift, inready_cnt, inready_cycle;
    int         write_cnt, seq_err, last_err, last_cnt, hold_err, stall_cycles;
    int         done_cycle, timeout;
    logic       busy0;
    logic [7:0] got [NUM_WORDS];

    // Drives wr_ready / prev_out_ready cycle by cycle and logs what the DUT did.
    task automatic drive_block(input int max_cycles, input int stall_mode,
                               input int drop_at, input int stop_addr);
        int         exp_addr = 0;
        int         stall5 = 0;
        logic       tog = 1'b1;
        logic       prev_stall = 1'b0;
        logic [6:0] hold_addr = '0;
        logic [7:0] hold_data = '0;
        logic       hold_last = 1'b0;
        bit         done = 1'b0;
        shift_cnt = 0; first_shift = -1; last_shift = -1; inready_cnt = 0; inready_cycle = -1;
        write_cnt = 0; seq_err = 0; last_err = 0; last_cnt = 0; hold_err = 0; stall_cycles = 0;
        done_cycle = -1; timeout = 0; busy0 = 1'bx;
        for (int i = 0; i < NUM_WORDS; i++) got[i] = 'x;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(negedge clk);
            if (c == 0) busy0 = busy;
            if (prev_shift === 1'b1) begin
                shift_cnt++;
                if (first_shift < 0) first_shift = c;
                last_shift = c;
                if (shift_cnt == drop_at) prev_out_ready = 1'b0;
            end
            if (in_ready === 1'b1) begin
                inready_cnt++;
                inready_cycle = c;
            end
            if (prev_stall && (wr_valid !== 1'b1 || wr_addr !== hold_addr ||
                               wr_data !== hold_data || wr_last !== hold_last))
                hold_err++;
            if (wr_valid === 1'b1 && stop_addr >= 0 && int'(wr_addr) == stop_addr) begin
                done = 1'b1;
            end else begin
                if (wr_valid !== 1'b1 || stall_mode == 0) wr_ready = 1'b1;
                else if (wr_addr < 7'd5) wr_ready = 1'b1;
                else if (wr_addr == 7'd5 && stall5 < 4) begin
                    wr_ready = 1'b0;
                    stall5++;
                end else begin
                    wr_ready = tog;
                    tog = ~tog;
                end
                if (wr_valid === 1'b1 && !wr_ready) stall_cycles++;
                if (wr_valid === 1'b1 && wr_ready) begin
                    write_cnt++;
                    if (int'(wr_addr) != exp_addr) seq_err++;
                    exp_addr++;
                    got[wr_addr] = wr_data;
                    if (wr_last !== (wr_addr == 7'd79)) last_err++;
                    if (wr_last === 1'b1) begin
                        last_cnt++;
                        done_cycle = c;
                        done = 1'b1;
                    end
                end
                prev_stall = (wr_valid === 1'b1 && !wr_ready);
                hold_addr  = wr_addr;
                hold_data  = wr_data;
                hold_last  = wr_last;
            end
        end
        if (!done) timeout = 1;
    endtask

    task automatic test_reset();
        int busy_bad = 0;
        int shift_bad = 0;
        prev_out_ready = 1'b1;
        wr_ready = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (prev_shift !== 1'b0) begin errors++; $display("[TB] FAIL reset_prev_shift got %b exp 0", prev_shift); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_valid got %b exp 0", wr_valid); end
        checks++; if (wr_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_last got %b exp 0", wr_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        checks++; if (wr_addr !== 7'd0) begin errors++; $display("[TB] FAIL reset_wr_addr got %0d exp 0", wr_addr); end
        prev_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_idx = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_bad++;
            if (prev_shift !== 1'b0) shift_bad++;
        end
        checks++; if (busy_bad != 0) begin errors++; $display("[TB] FAIL idle_busy got %0d high cycles exp 0", busy_bad); end
        checks++; if (shift_bad != 0) begin errors++; $display("[TB] FAIL idle_shift got %0d high cycles exp 0", shift_bad); end
    endtask

    task automatic test_single_block();
        model_idx = 0; base0 = 8'h01; base1 = 8'h00;
        prev_out_ready = 1'b1;
        drive_block(400, 0, -1, -1);
        prev_out_ready = 1'b0;
        checks++; if (timeout != 0) begin errors++; $display("[TB] FAIL single_timeout got %0d exp 0", timeout); end
        checks++; if (shift_cnt != 80) begin errors++; $display("[TB] FAIL single_shift_cnt got %0d exp 80", shift_cnt); end
        checks++; if (first_shift != 0 || last_shift != 79) begin errors++; $display("[TB] FAIL single_shift_window got %0d..%0d exp 0..79", first_shift, last_shift); end
        checks++; if (inready_cnt != 1) begin errors++; $display("[TB] FAIL single_in_ready_cnt got %0d exp 1", inready_cnt); end
        checks++; if (inready_cycle != 80) begin errors++; $display("[TB] FAIL single_in_ready_cycle got %0d exp 80", inready_cycle); end
        checks++; if (write_cnt != 80) begin errors++; $display("[TB] FAIL single_write_cnt got %0d exp 80", write_cnt); end
        checks++; if (seq_err != 0) begin errors++; $display("[TB] FAIL single_addr_seq got %0d errs exp 0", seq_err); end
        checks++; if (last_err != 0 || last_cnt != 1) begin errors++; $display("[TB] FAIL single_wr_last got errs %0d cnt %0d exp 0 1", last_err, last_cnt); end
        checks++; if (done_cycle != 160) begin errors++; $display("[TB] FAIL single_done_cycle got %0d exp 160", done_cycle); end
        for (int k = 0; k < NUM_WORDS; k++) begin
            checks++; if (got[k] !== 8'(8'h01 + k)) begin errors++; $display("[TB] FAIL single_data[%0d] got %h exp %h", k, got[k], 8'(8'h01 + k)); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_end_idle got busy %b valid %b exp 0 0", busy, wr_valid); end
    endtask

    task automatic test_stall();
        model_idx = 0; base0 = 8'h01;
        prev_out_ready = 1'b1;
        drive_block(600, 1, -1, -1);
        prev_out_ready = 1'b0;
        checks++; if (timeout != 0) begin errors++; $display("[TB] FAIL stall_timeout got %0d exp 0", timeout); end
        checks++; if (write_cnt != 80) begin errors++; $display("[TB] FAIL stall_write_cnt got %0d exp 80", write_cnt); end
        checks++; if (seq_err != 0) begin errors++; $display("[TB] FAIL stall_addr_seq got %0d errs exp 0", seq_err); end
        checks++; if (hold_err != 0) begin errors++; $display("[TB] FAIL stall_hold got %0d errs exp 0", hold_err); end
        checks++; if (stall_cycles != 78) begin errors++; $display("[TB] FAIL stall_cycles got %0d exp 78", stall_cycles); end
        checks++; if (last_err != 0 || last_cnt != 1) begin errors++; $display("[TB] FAIL stall_wr_last got errs %0d cnt %0d exp 0 1", last_err, last_cnt); end
        checks++; if (done_cycle != 238) begin errors++; $display("[TB] FAIL stall_done_cycle got %0d exp 238", done_cycle); end
        for (int k = 0; k < NUM_WORDS; k++) begin
            checks++; if (got[k] !== 8'(8'h01 + k)) begin errors++; $display("[TB] FAIL stall_data[%0d] got %h exp %h", k, got[k], 8'(8'h01 + k)); end
        end
        @(negedge clk);
    endtask

    task automatic test_drop();
        model_idx = 0; base0 = 8'h10;
        prev_out_ready = 1'b1;
        drive_block(400, 0, 10, -1);
        checks++; if (timeout != 0) begin errors++; $display("[TB] FAIL drop_timeout got %0d exp 0", timeout); end
        checks++; if (shift_cnt != 80) begin errors++; $display("[TB] FAIL drop_shift_cnt got %0d exp 80", shift_cnt); end
        checks++; if (inready_cnt != 1) begin errors++; $display("[TB] FAIL drop_in_ready_cnt got %0d exp 1", inready_cnt); end
        checks++; if (write_cnt != 80 || done_cycle != 160) begin errors++; $display("[TB] FAIL drop_writes got %0d at %0d exp 80 at 160", write_cnt, done_cycle); end
        for (int k = 0; k < NUM_WORDS; k++) begin
            checks++; if (got[k] !== 8'(8'h10 + k)) begin errors++; $display("[TB] FAIL drop_data[%0d] got %h exp %h", k, got[k], 8'(8'h10 + k)); end
        end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_end_idle got busy %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        model_idx = 0; base0 = 8'hA0; base1 = 8'h50;
        prev_out_ready = 1'b1;
        drive_block(400, 0, -1, -1);
        checks++; if (timeout != 0 || done_cycle != 160) begin errors++; $display("[TB] FAIL b2b_first_done got timeout %0d cycle %0d exp 0 160", timeout, done_cycle); end
        for (int k = 0; k < NUM_WORDS; k++) begin
            checks++; if (got[k] !== 8'(8'hA0 + k)) begin errors++; $display("[TB] FAIL b2b_first_data[%0d] got %h exp %h", k, got[k], 8'(8'hA0 + k)); end
        end
        drive_block(400, 0, -1, -1);
        prev_out_ready = 1'b0;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap got busy %b exp 0", busy0); end
        checks++; if (first_shift != 1) begin errors++; $display("[TB] FAIL b2b_second_pull got cycle %0d exp 1", first_shift); end
        checks++; if (shift_cnt != 80 || seq_err != 0) begin errors++; $display("[TB] FAIL b2b_second_counts got shifts %0d seqerr %0d exp 80 0", shift_cnt, seq_err); end
        checks++; if (timeout != 0 || done_cycle != 161) begin errors++; $display("[TB] FAIL b2b_second_done got timeout %0d cycle %0d exp 0 161", timeout, done_cycle); end
        for (int k = 0; k < NUM_WORDS; k++) begin
            checks++; if (got[k] !== 8'(8'h50 + k)) begin errors++; $display("[TB] FAIL b2b_second_data[%0d] got %h exp %h", k, got[k], 8'(8'h50 + k)); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_push();
        model_idx = 0; base0 = 8'h20;
        prev_out_ready = 1'b1;
        drive_block(400, 0, -1, 40);
        checks++; if (timeout != 0 || write_cnt != 40) begin errors++; $display("[TB] FAIL midrst_reach got timeout %0d writes %0d exp 0 40", timeout, write_cnt); end
        #1 rst = 1'b1;
        #1;
        checks++; if (wr_valid !== 1'b0 || busy !== 1'b0 || wr_addr !== 7'd0) begin errors++; $display("[TB] FAIL midrst_async got valid %b busy %b addr %0d exp 0 0 0", wr_valid, busy, wr_addr); end
        repeat (2) @(negedge clk);
        model_idx = 0; base0 = 8'h60;
        rst = 1'b0;
        drive_block(400, 0, -1, -1);
        prev_out_ready = 1'b0;
        checks++; if (first_shift != 0 || shift_cnt != 80) begin errors++; $display("[TB] FAIL midrst_pull got start %0d shifts %0d exp 0 80", first_shift, shift_cnt); end
        checks++; if (seq_err != 0 || write_cnt != 80) begin errors++; $display("[TB] FAIL midrst_writes got seqerr %0d writes %0d exp 0 80", seq_err, write_cnt); end
        checks++; if (timeout != 0 || done_cycle != 160) begin errors++; $display("[TB] FAIL midrst_done got timeout %0d cycle %0d exp 0 160", timeout, done_cycle); end
        for (int k = 0; k < NUM_WORDS; k++) begin
            checks++; if (got[k] !== 8'(8'h60 + k)) begin errors++; $display("[TB] FAIL midrst_data[%0d] got %h exp %h", k, got[k], 8'(8'h60 + k)); end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        prev_out_ready = 1'b0;
        prev_data = 8'h00;
        wr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single_block();
        test_stall();
        test_drop();
        test_back_to_back();
        test_reset_mid_push();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
